// File: rtl/noc_pkg.sv
// ============================================================================
//  Module   : noc_pkg
//  Brief    : Shared flit-layout helpers, FSM encoding and host-node defaults
//             for the mesh processing-element responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int HOST_X_DEFAULT = 0;
    localparam int HOST_Y_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_SEND = 2'd2
    } pe_state_e;

    // Flit fields are packed LSB first: dest X, dest Y, packet number, payload.
    function automatic int x_lsb();
        return 0;
    endfunction

    function automatic int y_lsb(input int x_size);
        return x_size;
    endfunction

    function automatic int pck_lsb(input int x_size, input int y_size);
        return x_size + y_size;
    endfunction

    function automatic int data_lsb(input int x_size, input int y_size, input int pck_num);
        return x_size + y_size + pck_num;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_sync_fifo.sv
// ============================================================================
//  Module   : noc_sync_fifo
//  Brief    : Single-clock FIFO, power-of-2 depth, push blocked when full and
//             pop blocked when empty; simultaneous push/pop both honoured.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_pe_responder.sv
// ============================================================================
//  Module   : noc_pe_responder
//  Brief    : Mesh PE endpoint: buffers request flits, byte-reverses the
//             payload one byte per cycle and replies to the host node.
//             Define PE_RESP_STATS_EN to add the o_pkt_count reply counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module noc_pe_responder
    import noc_pkg::*;
#(
    parameter int X           = 8,
    parameter int Y           = 8,
    parameter int pck_num     = 12,
    parameter int data_width  = 256,
    parameter int x_size      = $clog2(X),
    parameter int y_size      = $clog2(Y),
    parameter int total_width = x_size + y_size + pck_num + data_width,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOST_X      = HOST_X_DEFAULT,
    parameter int HOST_Y      = HOST_Y_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [total_width-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready
`ifdef PE_RESP_STATS_EN
    ,
    output logic [15:0]            o_pkt_count
`endif
);

    localparam int ITER     = data_width / 8;
    localparam int KW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PCK_LSB  = pck_lsb(x_size, y_size);
    localparam int DATA_LSB = data_lsb(x_size, y_size, pck_num);
    localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

    logic [total_width-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   unused_dest;

    pe_state_e              state_q, state_d;
    logic [data_width-1:0]  src_q, src_d;
    logic [data_width-1:0]  res_q, res_d;
    logic [pck_num-1:0]     pck_q, pck_d;
    logic [KW-1:0]          k_q, k_d;

    assign o_ready = ~fifo_full;

    noc_sync_fifo #(
        .WIDTH (total_width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_valid & ~fifo_full),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The request's own destination is this node, so it carries no information.
    assign unused_dest = ^fifo_dout[PCK_LSB-1:0];

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        res_d    = res_q;
        pck_d    = pck_q;
        k_d      = k_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    src_d    = fifo_dout[DATA_LSB +: data_width];
                    pck_d    = fifo_dout[PCK_LSB +: pck_num];
                    res_d    = '0;
                    k_d      = '0;
                    state_d  = ST_PROC;
                end
            end
            ST_PROC: begin
                for (int i = 0; i < ITER; i++) begin
                    if (k_q == KW'(i)) begin
                        res_d[(ITER-1-i)*8 +: 8] = src_q[i*8 +: 8];
                    end
                end
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            res_q   <= '0;
            pck_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            pck_q   <= pck_d;
            k_q     <= k_d;
        end
    end

    // Reply fields are straight from registers, so o_data holds during stalls.
    assign o_valid = (state_q == ST_SEND);
    assign o_data  = {res_q, pck_q, y_size'(HOST_Y), x_size'(HOST_X)};

`ifdef PE_RESP_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (o_valid && i_ready && (pkt_count_q != 16'hFFFF)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign o_pkt_count = pkt_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_pe_responder.sv
// ============================================================================
//  Module   : tb_noc_pe_responder
//  Brief    : Randomized scoreboard bench for noc_pe_responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_noc_pe_responder;

    localparam int DW   = 256;
    localparam int PN   = 12;
    localparam int XS   = 3;
    localparam int YS   = 3;
    localparam int TW   = XS + YS + PN + DW;
    localparam int ITER = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [TW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
`ifdef PE_RESP_STATS_EN
    logic [15:0]   o_pkt_count;
`endif

    noc_pe_responder #(
        .X (8), .Y (8), .pck_num (PN), .data_width (DW), .FIFO_DEPTH (4),
        .HOST_X (0), .HOST_Y (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
`ifdef PE_RESP_STATS_EN
        ,
        .o_pkt_count (o_pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            errors  = 0;
    int            cyc     = 0;
    int            hs_count = 0;
    int            rise_cyc = 0;
    int            accept_cyc = 0;
    int            stream_prev = -1;
    bit            stream_mode = 0;
    logic [TW-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_vec(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: reply payload is the request payload with byte order reversed,
    // addressed to host (0,0), packet number unchanged.
    function automatic logic [TW-1:0] model_reply(input logic [PN-1:0] pck, input logic [DW-1:0] pay);
        logic [DW-1:0] r;
        for (int i = 0; i < ITER; i++) r[8*i +: 8] = pay[8*(ITER-1-i) +: 8];
        return {r, pck, {(XS+YS){1'b0}}};
    endfunction

    function automatic logic [DW-1:0] rand_pay();
        logic [DW-1:0] p;
        for (int i = 0; i < DW/32; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    // Monitor: pops the scoreboard on every reply handshake and checks stalls.
    bit            prev_stall = 0;
    bit            prev_hs    = 0;
    bit            prev_valid = 0;
    logic [TW-1:0] held;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_hs    = 0;
            prev_valid = 0;
            hs_count   = 0;
        end else begin
            if (prev_hs) check_int("valid_drop", int'(o_valid), 0);
            if (prev_stall) begin
                check_int("stall_valid", int'(o_valid), 1);
                check_vec("stall_hold", o_data, held);
            end
            if (o_valid && !prev_valid) rise_cyc = cyc;
            prev_stall = 0;
            prev_hs    = 0;
            if (o_valid) begin
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_reply: got %h expected none", o_data);
                    end else begin
                        check_vec("reply", o_data, exp_q.pop_front());
                    end
                    hs_count++;
                    if (stream_mode && stream_prev >= 0) check_int("spacing", cyc - stream_prev, ITER + 2);
                    stream_prev = cyc;
                    prev_hs = 1;
                end else begin
                    prev_stall = 1;
                    held = o_data;
                end
            end
            prev_valid = o_valid;
        end
    end

    // Offers one request and holds i_valid until it is taken; returns at posedge+1.
    task automatic send(input logic [PN-1:0] pck, input logic [DW-1:0] pay,
                        input logic [YS-1:0] dy, input logic [XS-1:0] dx);
        int t = 0;
        bit ok = 0;
        i_data  = {pay, pck, dy, dx};
        i_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1;
                break;
            end
            t++;
            if (t > 2000) break;
        end
        if (ok) begin
            exp_q.push_back(model_reply(pck, pay));
            accept_cyc = cyc + 1;
        end else begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: got o_ready=0 expected 1 within 2000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check_int("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pay;
        logic [DW-1:0] pay6;
        int            t;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_ready", int'(o_ready), 1);
        check_int("rst_valid", int'(o_valid), 0);
        check_vec("rst_data", o_data, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request with byte i = i: reply should carry bytes 0x1F..0x00.
        for (int i = 0; i < ITER; i++) pay[8*i +: 8] = 8'(i);
        send(12'h123, pay, 3'd2, 3'd3);
        i_valid = 1'b0;
        wait_idle();
        check_int("hs_after_first", hs_count, 1);
        // Accept edge ends cycle c; o_valid is first seen after edge c+ITER+1, i.e. in cycle c+ITER+2.
        check_int("latency", rise_cyc - accept_cyc, ITER + 1);

        // Reply backpressure held for 10 cycles.
        i_ready = 1'b0;
        send(PN'($urandom), rand_pay(), YS'($urandom), XS'($urandom));
        i_valid = 1'b0;
        t = 0;
        while (!o_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_int("bp_valid_rise", int'(o_valid), 1);
        repeat (10) @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_idle();

        // FIFO fill: five accepted while reply stalls, sixth refused.
        i_ready = 1'b0;
        for (int n = 1; n <= 5; n++) send(PN'(n), rand_pay(), YS'($urandom), XS'($urandom));
        pay6    = rand_pay();
        i_data  = {pay6, 12'd6, 3'd1, 3'd1};
        i_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_int("full_oready", int'(o_ready), 0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        send(12'd6, pay6, 3'd1, 3'd1);
        i_valid = 1'b0;
        wait_idle();

        // Back-to-back streaming with i_valid held high.
        stream_prev = -1;
        stream_mode = 1;
        for (int n = 0; n < 8; n++) send(PN'($urandom), rand_pay(), YS'($urandom), XS'($urandom));
        i_valid = 1'b0;
        wait_idle();
        stream_mode = 0;

        // Reset while processing byte k=10.
        send(PN'($urandom), rand_pay(), YS'($urandom), XS'($urandom));
        i_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_int("midrst_valid", int'(o_valid), 0);
        check_int("midrst_ready", int'(o_ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(12'h7, rand_pay(), YS'($urandom), XS'($urandom));
        i_valid = 1'b0;
        wait_idle();
        repeat (60) @(posedge clk);
        #1;
        check_int("post_rst_replies", hs_count, 1);
`ifdef PE_RESP_STATS_EN
        check_int("pkt_count", int'(o_pkt_count), hs_count);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
